// File: rtl/bus_gate_arb_if.sv
// rtl/bus_gate_arb_if.sv - request/gate-enable bundle between bus drivers and the gate arbiter
interface bus_gate_arb_if #(
    parameter int N     = 4,
    parameter int IDX_W = 3
);
    logic [N-1:0]     req;
    logic [N-1:0]     en;
    logic [IDX_W-1:0] drv_idx;
    logic             busy;
    logic             timeout;

    // Arbiter side: consumes requests, drives the tri-state gate enables.
    modport master (
        input  req,
        output en,
        output drv_idx,
        output busy,
        output timeout
    );

    // Requester side: raises requests, observes the gates.
    modport slave (
        output req,
        input  en,
        input  drv_idx,
        input  busy,
        input  timeout
    );
endinterface

// File: rtl/bus_gate_arb.sv
// rtl/bus_gate_arb.sv - round-robin break-before-make arbiter for tri-state bus gate enables
// Optional hold limit with sticky timeout flag: define BUS_ARB_TIMEOUT_EN.
module bus_gate_arb #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDX_W    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    bus_gate_arb_if.master  bus
);
    if (N < 2 || N > 8 || (1 << IDX_W) < N || MAX_HOLD < 2) begin : g_bad_cfg
        $error("bus_gate_arb: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t           state, state_n;
    logic [N-1:0]     en_q, en_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             busy_q, busy_n;
    logic [IDX_W-1:0] ptr_q, ptr_n;
    logic             found;
    logic [IDX_W-1:0] win;
    logic             owner_req;
    logic             release_grant;
    logic [IDX_W-1:0] ptr_next;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             timeout_q, timeout_n;
    logic             expired;
`endif

    // First set request at or above ptr, wrapping modulo N.
    always_comb begin
        int j;
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N) j = j - N;
            if (!found && ((req_vec() & (ONE << j)) != '0)) begin
                found = 1'b1;
                win   = IDX_W'(j);
            end
        end
    end

    function automatic logic [N-1:0] req_vec();
        return bus.req;
    endfunction

    // en is one-hot on the owner, so this picks out req[w] without an index.
    assign owner_req = |(bus.req & en_q);
    assign ptr_next  = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);

`ifdef BUS_ARB_TIMEOUT_EN
    assign expired       = (cnt_q == CNT_W'(MAX_HOLD));
    assign release_grant = !owner_req || expired;
`else
    assign release_grant = !owner_req;
`endif

    always_comb begin
        state_n = state;
        en_n    = en_q;
        idx_n   = idx_q;
        busy_n  = busy_q;
        ptr_n   = ptr_q;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_n     = cnt_q;
        timeout_n = timeout_q;
`endif
        case (state)
            DRIVE: begin
                if (release_grant) begin
                    state_n = TURN;
                    en_n    = '0;
                    idx_n   = '0;
                    busy_n  = 1'b0;
                    ptr_n   = ptr_next;
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_n = '0;
                    if (owner_req) timeout_n = 1'b1;
`endif
                end else begin
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_n = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                // IDLE and TURN arbitrate identically; en is already zero here.
                if (found) begin
                    state_n = DRIVE;
                    en_n    = ONE << win;
                    idx_n   = win;
                    busy_n  = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_n = CNT_W'(1);
`endif
                end else begin
                    state_n = IDLE;
                    en_n    = '0;
                    idx_n   = '0;
                    busy_n  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            en_q   <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            ptr_q  <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            en_q   <= en_n;
            idx_q  <= idx_n;
            busy_q <= busy_n;
            ptr_q  <= ptr_n;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q     <= cnt_n;
            timeout_q <= timeout_n;
`endif
        end
    end

    assign bus.en      = en_q;
    assign bus.drv_idx = idx_q;
    assign bus.busy    = busy_q;
`ifdef BUS_ARB_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_bus_gate_arb.sv
// tb/tb_bus_gate_arb.sv - directed self-checking bench for bus_gate_arb (N=4, MAX_HOLD=8)
module tb_bus_gate_arb;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    bus_gate_arb_if #(.N(4), .IDX_W(3)) bus ();

    bus_gate_arb #(.N(4), .MAX_HOLD(8), .IDX_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            tick();
            tests++;
            if (bus.en !== 4'b0000 || bus.busy !== 1'b0 || bus.drv_idx !== 3'd0 || bus.timeout !== 1'b0) begin
                fails++;
                $display("FAIL reset cycle %0d: en=%b busy=%b idx=%0d to=%b, need 0000/0/0/0",
                         c, bus.en, bus.busy, bus.drv_idx, bus.timeout);
            end
        end
        bus.req = 4'b0000;
        rst_n   = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0100;
        tick();
        tests++;
        if (bus.en !== 4'b0100 || bus.drv_idx !== 3'd2 || bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL single grant: en=%b idx=%0d busy=%b, need 0100/2/1", bus.en, bus.drv_idx, bus.busy);
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            tests++;
            if (bus.en !== 4'b0100) begin
                fails++;
                $display("FAIL single hold k+%0d: en=%b, need 0100", c, bus.en);
            end
        end
        bus.req = 4'b0000;
        for (int c = 5; c <= 7; c++) begin
            tick();
            tests++;
            if (bus.en !== 4'b0000 || bus.busy !== 1'b0 || bus.drv_idx !== 3'd0) begin
                fails++;
                $display("FAIL single release k+%0d: en=%b busy=%b idx=%0d, need 0000/0/0",
                         c, bus.en, bus.busy, bus.drv_idx);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_en;
        do_reset();
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_en = 4'b0001 << (g % 4);
            tick();
            tests++;
            if (bus.en !== exp_en || bus.drv_idx !== 3'(g % 4)) begin
                fails++;
                $display("FAIL rr grant %0d: en=%b idx=%0d, need %b/%0d", g, bus.en, bus.drv_idx, exp_en, g % 4);
            end
            tick();
            tests++;
            if (bus.en !== exp_en) begin
                fails++;
                $display("FAIL rr hold %0d: en=%b, need %b", g, bus.en, exp_en);
            end
            bus.req = 4'b1111 & ~exp_en;
            tick();
            tests++;
            if (bus.en !== 4'b0000 || bus.busy !== 1'b0) begin
                fails++;
                $display("FAIL rr gap %0d: en=%b busy=%b, need 0000/0", g, bus.en, bus.busy);
            end
            bus.req = 4'b1111;
        end
    endtask

    task automatic test_handoff();
        logic [3:0] seq [4];
        seq[0] = 4'b0001;
        seq[1] = 4'b0001;
        seq[2] = 4'b0000;
        seq[3] = 4'b1000;
        do_reset();
        bus.req = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            tick();
            tests++;
            if (bus.en !== seq[c] || !$onehot0(bus.en)) begin
                fails++;
                $display("FAIL handoff step %0d: en=%b, need %b", c, bus.en, seq[c]);
            end
            if (c == 1) bus.req = 4'b1000;
        end
    endtask

    task automatic test_timeout();
        logic [3:0] exp_en;
        logic       exp_to;
        do_reset();
        bus.req = 4'b0010;
        for (int i = 1; i <= 20; i++) begin
            tick();
`ifdef BUS_ARB_TIMEOUT_EN
            exp_en = (((i - 1) % 9) == 8) ? 4'b0000 : 4'b0010;
            exp_to = (i >= 9);
`else
            exp_en = 4'b0010;
            exp_to = 1'b0;
`endif
            tests++;
            if (bus.en !== exp_en || bus.timeout !== exp_to) begin
                fails++;
                $display("FAIL timeout cycle %0d: en=%b to=%b, need %b/%b", i, bus.en, bus.timeout, exp_en, exp_to);
            end
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b0000;
        tick();
        bus.req = 4'b1000;
        tick();
        tests++;
        if (bus.en !== 4'b1000 || bus.drv_idx !== 3'd3) begin
            fails++;
            $display("FAIL async pre-grant: en=%b idx=%0d, need 1000/3", bus.en, bus.drv_idx);
        end
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.en !== 4'b0000 || bus.busy !== 1'b0 || bus.drv_idx !== 3'd0) begin
            fails++;
            $display("FAIL async clear: en=%b busy=%b idx=%0d, need 0000/0/0", bus.en, bus.busy, bus.drv_idx);
        end
        tick();
        rst_n   = 1'b1;
        bus.req = 4'b1001;
        tick();
        tests++;
        if (bus.en !== 4'b0001 || bus.drv_idx !== 3'd0) begin
            fails++;
            $display("FAIL async ptr reset: en=%b idx=%0d, need 0001/0", bus.en, bus.drv_idx);
        end
        bus.req = 4'b0000;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_handoff();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bus_gate_arb.md
Name: bus_gate_arb

Overview:
- Arbitrates the shared LC-3 datapath bus between N tri-state drivers (PC, MARMUX, ALU, MDR gates).
- Produces the registered, one-hot, active-high enables that feed the `en` inputs of the `tri_h` bus drivers directly.
- Guarantees break-before-make: at least one all-disabled cycle between any two drivers, so the bus is never double-driven.

Parameters:
- N, 4, number of bus requesters / tri-state drivers (2..8).
- MAX_HOLD, 8, maximum consecutive drive cycles per grant; used only when `BUS_ARB_TIMEOUT_EN` is defined (≥2).
- IDX_W, 3, width of the encoded grant index; must satisfy 2**IDX_W ≥ N.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  per-driver bus request, level-sensitive, sampled on `clk` rising edge.
- en  out  N  registered one-hot gate enables; connect to `tri_h` enable pins.
- drv_idx  out  IDX_W  encoded index of the driver in `en`; 0 when `en` == 0.
- busy  out  1  high while any `en` bit is high (OR of `en`, registered).
- timeout  out  1  sticky flag: a grant was force-released (see Optional Feature); constant 0 when the feature is compiled out.

Behaviour:
- Reset: `rst_n` low asynchronously forces `en` = 0, `drv_idx` = 0, `busy` = 0, `timeout` = 0, pointer `ptr` = 0, state = IDLE. Outputs clear immediately, with no clock edge needed. Deassertion takes effect on the next rising edge.
- States: IDLE, DRIVE, TURN. All outputs are registered, with no combinational path from `req` to `en`.
- IDLE:
  - `en` = 0.
  - If `req` != 0 at an edge: select winner w = first set bit of `req` searching from `ptr` upward, wrapping modulo N.
  - Go to DRIVE, `en` = 1<<w, `drv_idx` = w, `busy` = 1.
  - Latency: `req` seen at edge k → `en` high after edge k (visible in cycle k+1).
- DRIVE:
  - Hold `en` while `req[w]` = 1. Other `req` bits are ignored.
  - When `req[w]` = 0 at an edge: go to TURN, `en` = 0, `busy` = 0, `drv_idx` = 0, `ptr` = (w+1) mod N.
- TURN:
  - Exactly one cycle with `en` = 0.
  - At the next edge, arbitrate exactly as in IDLE: go to DRIVE if `req` != 0, else IDLE.
  - Minimum bus gap between drivers is therefore one cycle.
- Invariants:
  - `en` is one-hot or zero at all times.
  - `en` never changes directly from one nonzero value to a different nonzero value.
  - `drv_idx` and `busy` always agree with `en`.
- Simultaneous events:
  - Winner drops its request in the same cycle another requester rises: normal TURN, then the new grant.
  - A request that drops while `en` is already being registered for it still receives a one-cycle grant, then TURN.
- Fairness: round-robin. Each requester waits at most N-1 other grants.
- Reset mid-DRIVE: `en` drops immediately, `ptr` returns to 0, and the in-flight grant is lost.

Optional Feature:
- Macro: `BUS_ARB_TIMEOUT_EN`.
- Defined:
  - A drive counter counts cycles in DRIVE.
  - When `en[w]` has been high for MAX_HOLD cycles, force TURN even if `req[w]` = 1.
  - `ptr` advances to (w+1) mod N and `timeout` sets to 1; it stays set until reset.
  - If w is still the only requester, it is re-granted after the TURN cycle.
- Undefined: no counter; a grant is held for as long as `req[w]` = 1; `timeout` is tied to 0.

Test Plan (N=4, MAX_HOLD=8):
- Reset: hold `rst_n`=0, `req`=4'b1111 → `en`=4'b0000, `busy`=0, `drv_idx`=0, `timeout`=0 for all cycles.
- Single request:
  - `req`=4'b0100 rises before edge k → `en`=4'b0100, `drv_idx`=2, `busy`=1 after edge k.
  - `req` cleared before edge k+5 → `en`=0 after k+5 and stays 0 (IDLE).
- Round-robin: `req`=4'b1111, each winner drops its own bit 2 cycles after grant, then reasserts → grant order 0001, 0010, 0100, 1000, 0001; each grant separated by exactly one `en`=0 cycle.
- Handoff: `req[0]` drops and `req[3]` rises in the same cycle → `en` sequence 0001, 0000, 1000; bench asserts `en` is one-hot-or-zero on every cycle.
- Timeout (macro defined): `req`=4'b0010 held 20 cycles → `en`=0010 for exactly 8 cycles, then 0000 for 1 cycle, then 0010 again; `timeout`=1 from the first forced release. With the macro undefined → `en`=0010 for all 20 cycles and `timeout`=0.
- Async reset mid-drive: while `en`=4'b1000, pulse `rst_n` low between edges → `en`=0 before the next clock edge. After release with `req`=4'b1001 → grant goes to bit 0 (`ptr` reset).
